// File: rtl/async_receiver.sv
// Serial receiver with 16x oversampling. It recovers 8N1 bytes from an asynchronous RxD line,
// flags bad stop bits, and reports when the line has been idle for at least 10 bit times.
module async_receiver #(
    parameter int ClkFrequency          = 10000000,
    parameter int Baud                  = 115200,
    parameter int BaudGeneratorAccWidth = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_frame_err,
    output logic       RxD_busy,
    output logic       RxD_idle,
    output logic       RxD_endofpacket
);

    // Rounded Baud*16*2^W/ClkFrequency. The arithmetic is 64-bit because the product does not fit in 32 bits.
    localparam logic [63:0] IncWide =
        ((64'(Baud) << (BaudGeneratorAccWidth + 4)) + 64'(ClkFrequency / 2)) / 64'(ClkFrequency);
    localparam logic [BaudGeneratorAccWidth:0] Inc = IncWide[BaudGeneratorAccWidth:0];
    localparam logic [7:0] GapMax = 8'd160;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_e;

    logic                           rxMeta;
    logic                           rxSync;
    logic [BaudGeneratorAccWidth:0] baudAcc;
    logic                           tick;
    state_e                         state;
    logic [3:0]                     tcnt;
    logic [2:0]                     bidx;
    logic [7:0]                     shiftReg;
    logic [7:0]                     gapCnt;

    assign tick            = baudAcc[BaudGeneratorAccWidth];
    assign RxD_busy        = (state != IDLE);
    assign RxD_idle        = (gapCnt == GapMax);

    // NOTE: all state below updates with non-blocking assignments, so every branch reads pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Synchronizer flops reset to the idle line level, so reset release never looks like a start edge.
            rxMeta          <= 1'b1;
            rxSync          <= 1'b1;
            baudAcc         <= '0;
            state           <= IDLE;
            tcnt            <= 4'd0;
            bidx            <= 3'd0;
            shiftReg        <= 8'h00;
            gapCnt          <= 8'd0;
            RxD_data        <= 8'h00;
            RxD_data_ready  <= 1'b0;
            RxD_frame_err   <= 1'b0;
            RxD_endofpacket <= 1'b0;
        end else begin
            rxMeta          <= RxD;
            rxSync          <= rxMeta;
            baudAcc         <= {1'b0, baudAcc[BaudGeneratorAccWidth-1:0]} + Inc;
            RxD_data_ready  <= 1'b0;
            RxD_frame_err   <= 1'b0;
            RxD_endofpacket <= 1'b0;

            if (tick) begin
                case (state)
                    IDLE: begin
                        if (!rxSync) begin
                            state <= START;
                            tcnt  <= 4'd0;
                        end
                    end
                    START: begin
                        tcnt <= tcnt + 4'd1;
                        // The start bit is confirmed near its middle. A line that is high again here is a glitch.
                        if (tcnt == 4'd6) begin
                            if (rxSync) begin
                                state <= IDLE;
                            end else begin
                                state <= DATA;
                                tcnt  <= 4'd0;
                                bidx  <= 3'd0;
                            end
                        end
                    end
                    DATA: begin
                        tcnt <= tcnt + 4'd1;
                        if (tcnt == 4'd15) begin
                            shiftReg <= {rxSync, shiftReg[7:1]};
                            bidx     <= bidx + 3'd1;
                            if (bidx == 3'd7) state <= STOP;
                        end
                    end
                    STOP: begin
                        tcnt <= tcnt + 4'd1;
                        if (tcnt == 4'd15) begin
                            if (rxSync) begin
                                RxD_data       <= shiftReg;
                                RxD_data_ready <= 1'b1;
                                state          <= IDLE;
                            end else begin
                                RxD_frame_err  <= 1'b1;
                                state          <= WAIT_HIGH;
                            end
                        end
                    end
                    WAIT_HIGH: begin
                        if (rxSync) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end

            // The gap counter only measures idle-high time spent in IDLE.
            if (state != IDLE) begin
                gapCnt <= 8'd0;
            end else if (tick) begin
                if (!rxSync) begin
                    gapCnt <= 8'd0;
                end else if (gapCnt != GapMax) begin
                    gapCnt <= gapCnt + 8'd1;
                    if (gapCnt == GapMax - 8'd1) RxD_endofpacket <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_async_receiver.sv
// Testbench for async_receiver. Each scenario task drives frames and checks the receiver
// against a byte-level model of what the line carried.
`timescale 1ns/1ps
module tb_async_receiver;

    localparam int BitClks = 87;  // 10 MHz / 115200 baud, rounded

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       RxD   = 1'b1;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_frame_err;
    logic       RxD_busy;
    logic       RxD_idle;
    logic       RxD_endofpacket;

    int errors = 0;
    int checks = 0;

    // Monitor state
    logic [7:0] capQ[$];
    int         ferrCnt   = 0;
    int         eopCnt    = 0;
    int         widthErr  = 0;
    int         updErr    = 0;
    int         eopErr    = 0;
    bit         busySeen  = 0;
    logic       prevReady = 1'b0;
    logic       prevFerr  = 1'b0;
    logic       prevIdle  = 1'b0;
    logic       prevReset = 1'b1;
    logic [7:0] prevData  = 8'h00;

    // Model: last byte that arrived with a valid stop bit since the last reset
    logic [7:0] lastGood = 8'h00;

    always #50 clk = ~clk;

    async_receiver dut (
        .clk            (clk),
        .reset          (reset),
        .RxD            (RxD),
        .RxD_data       (RxD_data),
        .RxD_data_ready (RxD_data_ready),
        .RxD_frame_err  (RxD_frame_err),
        .RxD_busy       (RxD_busy),
        .RxD_idle       (RxD_idle),
        .RxD_endofpacket(RxD_endofpacket)
    );

    always @(negedge clk) begin
        if (RxD_data_ready) capQ.push_back(RxD_data);
        if (RxD_frame_err) ferrCnt++;
        if (RxD_endofpacket) eopCnt++;
        if (RxD_busy) busySeen = 1;
        if ((RxD_data_ready && prevReady) || (RxD_frame_err && prevFerr)) widthErr++;
        if (!reset && !prevReset && (RxD_data !== prevData) && !RxD_data_ready) updErr++;
        if (RxD_endofpacket !== (RxD_idle && !prevIdle)) eopErr++;
        prevReady = RxD_data_ready;
        prevFerr  = RxD_frame_err;
        prevIdle  = RxD_idle;
        prevReset = reset;
        prevData  = RxD_data;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        RxD = v;
        wait_clks(BitClks);
    endtask

    // Leaves the line at the stop-bit level. Callers release a low stop bit themselves.
    task automatic send_byte(input logic [7:0] b, input bit stopOk);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stopOk);
    endtask

    task automatic clear_mon();
        capQ.delete();
        ferrCnt  = 0;
        eopCnt   = 0;
        widthErr = 0;
        updErr   = 0;
        eopErr   = 0;
        busySeen = 0;
    endtask

    task automatic test_reset();
        logic [7:0] obs[6];
        string      names[6];
        reset = 1'b1;
        RxD   = 1'b1;
        wait_clks(4);
        @(negedge clk);
        obs   = '{RxD_data, {7'd0, RxD_data_ready}, {7'd0, RxD_frame_err}, {7'd0, RxD_busy},
                  {7'd0, RxD_idle}, {7'd0, RxD_endofpacket}};
        names = '{"reset_data", "reset_ready", "reset_ferr", "reset_busy", "reset_idle", "reset_eop"};
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs[i] !== 8'h00) begin
                errors++;
                $display("FAIL %s: got %h expected 00", names[i], obs[i]);
            end
        end
        reset    = 1'b0;
        lastGood = 8'h00;
        wait_clks(20);
    endtask

    task automatic test_frame_a5();
        clear_mon();
        send_byte(8'hA5, 1'b1);
        RxD = 1'b1;
        wait_clks(20);
        lastGood = 8'hA5;
        checks++;
        if (capQ.size() != 1) begin
            errors++;
            $display("FAIL a5_ready_count: got %0d expected 1", capQ.size());
        end
        checks++;
        if (RxD_data !== lastGood) begin
            errors++;
            $display("FAIL a5_data: got %h expected %h", RxD_data, lastGood);
        end
        checks++;
        if (ferrCnt != 0 || widthErr != 0 || updErr != 0) begin
            errors++;
            $display("FAIL a5_pulses: ferr=%0d width=%0d upd=%0d expected all 0", ferrCnt, widthErr, updErr);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        RxD = 1'b0;
        wait_clks(17);
        RxD = 1'b1;
        wait_clks(100);
        checks++;
        if (!busySeen || RxD_busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy: seen=%0d now=%b expected seen=1 now=0", busySeen, RxD_busy);
        end
        checks++;
        if (capQ.size() != 0 || ferrCnt != 0) begin
            errors++;
            $display("FAIL glitch_pulses: ready=%0d ferr=%0d expected 0 0", capQ.size(), ferrCnt);
        end
        checks++;
        if (RxD_data !== lastGood) begin
            errors++;
            $display("FAIL glitch_data: got %h expected %h", RxD_data, lastGood);
        end
    endtask

    task automatic test_frame_error();
        logic [7:0] got;
        clear_mon();
        send_byte(8'h3C, 1'b0);
        wait_clks(2 * BitClks);
        RxD = 1'b1;
        wait_clks(2 * BitClks);
        checks++;
        if (ferrCnt != 1 || widthErr != 0) begin
            errors++;
            $display("FAIL ferr_count: got %0d (width errs %0d) expected 1", ferrCnt, widthErr);
        end
        checks++;
        if (capQ.size() != 0 || RxD_data !== lastGood) begin
            errors++;
            $display("FAIL ferr_data: ready=%0d data=%h expected 0 %h", capQ.size(), RxD_data, lastGood);
        end
        checks++;
        if (RxD_busy !== 1'b0) begin
            errors++;
            $display("FAIL ferr_busy: got %b expected 0", RxD_busy);
        end
        clear_mon();
        send_byte(8'h55, 1'b1);
        RxD = 1'b1;
        wait_clks(20);
        lastGood = 8'h55;
        got = (capQ.size() > 0) ? capQ[0] : 8'hxx;
        checks++;
        if (capQ.size() != 1 || got !== 8'h55 || ferrCnt != 0) begin
            errors++;
            $display("FAIL ferr_next: count=%0d data=%h ferr=%0d expected 1 55 0", capQ.size(), got, ferrCnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] g0, g1;
        clear_mon();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        RxD = 1'b1;
        wait_clks(20);
        lastGood = 8'hFF;
        g0 = (capQ.size() > 0) ? capQ[0] : 8'hxx;
        g1 = (capQ.size() > 1) ? capQ[1] : 8'hxx;
        checks++;
        if (capQ.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 2", capQ.size());
        end
        checks++;
        if (g0 !== 8'h00 || g1 !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_order: got %h %h expected 00 ff", g0, g1);
        end
        checks++;
        if (RxD_data !== lastGood || ferrCnt != 0) begin
            errors++;
            $display("FAIL b2b_final: data=%h ferr=%0d expected %h 0", RxD_data, ferrCnt, lastGood);
        end
    endtask

    task automatic test_idle();
        clear_mon();
        send_byte(8'h5A, 1'b1);
        RxD = 1'b1;
        wait_clks(700);
        checks++;
        if (RxD_idle !== 1'b0 || eopCnt != 0) begin
            errors++;
            $display("FAIL idle_early: idle=%b eop=%0d expected 0 0", RxD_idle, eopCnt);
        end
        wait_clks(400);
        checks++;
        if (RxD_idle !== 1'b1 || eopCnt != 1) begin
            errors++;
            $display("FAIL idle_reached: idle=%b eop=%0d expected 1 1", RxD_idle, eopCnt);
        end
        wait_clks(1000);
        checks++;
        if (eopCnt != 1 || eopErr != 0) begin
            errors++;
            $display("FAIL idle_eop_once: eop=%0d misaligned=%0d expected 1 0", eopCnt, eopErr);
        end
        fork
            send_byte(8'h96, 1'b1);
            begin
                wait_clks(20);
                checks++;
                if (RxD_idle !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_drop: got %b expected 0", RxD_idle);
                end
            end
        join
        RxD = 1'b1;
        wait_clks(20);
        lastGood = 8'h96;
        checks++;
        if (RxD_data !== lastGood) begin
            errors++;
            $display("FAIL idle_next_data: got %h expected %h", RxD_data, lastGood);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        logic [7:0] got;
        b = 8'hA3;
        clear_mon();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        RxD = b[4];
        wait_clks(43);
        reset = 1'b1;
        wait_clks(4);
        reset = 1'b0;
        lastGood = 8'h00;
        wait_clks(10);
        RxD = 1'b1;
        wait_clks(2 * BitClks);
        checks++;
        if (capQ.size() != 0 || ferrCnt != 0) begin
            errors++;
            $display("FAIL abort_pulses: ready=%0d ferr=%0d expected 0 0", capQ.size(), ferrCnt);
        end
        checks++;
        if (RxD_busy !== 1'b0 || RxD_data !== lastGood) begin
            errors++;
            $display("FAIL abort_state: busy=%b data=%h expected 0 %h", RxD_busy, RxD_data, lastGood);
        end
        clear_mon();
        send_byte(8'h81, 1'b1);
        RxD = 1'b1;
        wait_clks(20);
        lastGood = 8'h81;
        got = (capQ.size() > 0) ? capQ[0] : 8'hxx;
        checks++;
        if (capQ.size() != 1 || got !== 8'h81 || RxD_data !== lastGood) begin
            errors++;
            $display("FAIL abort_next: count=%0d pulse=%h data=%h expected 1 81 81", capQ.size(), got, RxD_data);
        end
    endtask

    task automatic test_random();
        logic [7:0] expQ[$];
        logic [7:0] b;
        bit         ok;
        int         expErr;
        expErr = 0;
        clear_mon();
        for (int n = 0; n < 10; n++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            send_byte(b, ok);
            if (ok) begin
                expQ.push_back(b);
                lastGood = b;
            end else begin
                expErr++;
                wait_clks($urandom_range(0, 2) * BitClks);
                RxD = 1'b1;
                wait_clks(BitClks);
            end
            RxD = 1'b1;
            wait_clks($urandom_range(0, 40));
        end
        wait_clks(20);
        checks++;
        if (capQ.size() != expQ.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d expected %0d", capQ.size(), expQ.size());
        end
        for (int i = 0; i < expQ.size(); i++) begin
            checks++;
            if (i >= capQ.size() || capQ[i] !== expQ[i]) begin
                errors++;
                $display("FAIL rand_byte%0d: got %h expected %h", i,
                         (i < capQ.size()) ? capQ[i] : 8'hxx, expQ[i]);
            end
        end
        checks++;
        if (ferrCnt != expErr) begin
            errors++;
            $display("FAIL rand_ferr: got %0d expected %0d", ferrCnt, expErr);
        end
        checks++;
        if (RxD_data !== lastGood || widthErr != 0 || updErr != 0) begin
            errors++;
            $display("FAIL rand_final: data=%h width=%0d upd=%0d expected %h 0 0", RxD_data, widthErr, updErr, lastGood);
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_idle();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/async_receiver.md
ASYNC_RECEIVER -- requirements
Module: async_receiver

Interface
REQ-001 The block SHALL have parameter ClkFrequency, default 10000000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter Baud, default 115200, meaning the line bit rate.
REQ-003 The block SHALL have parameter BaudGeneratorAccWidth, default 16, meaning the oversample phase-accumulator width (the register is BaudGeneratorAccWidth+1 bits).
REQ-004 Port clk SHALL be input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 Port reset SHALL be input, 1 bit: reset, synchronous, active-high.
REQ-006 Port RxD SHALL be input, 1 bit: asynchronous serial line, idle high.
REQ-007 Port RxD_data SHALL be output, 8 bits: last correctly framed byte.
REQ-008 Port RxD_data_ready SHALL be output, 1 bit: one-clk pulse when RxD_data is updated.
REQ-009 Port RxD_frame_err SHALL be output, 1 bit: one-clk pulse on a stop bit sampled low.
REQ-010 Port RxD_busy SHALL be output, 1 bit: high whenever the state is not IDLE.
REQ-011 Port RxD_idle SHALL be output, 1 bit: high after the line has been idle for at least 10 bit times.
REQ-012 Port RxD_endofpacket SHALL be output, 1 bit: one-clk pulse on the cycle RxD_idle rises.

Function
REQ-013 RxD SHALL pass through a 2-flop synchronizer (RxD_sync); all decisions SHALL use RxD_sync.
REQ-014 The oversample tick (16x Baud) SHALL come from a free-running phase accumulator: add Inc = round(Baud*16*2^BaudGeneratorAccWidth/ClkFrequency) to the lower BaudGeneratorAccWidth bits each clk; the carry bit is the tick. Default Inc = 12080.
REQ-015 A 4-bit tick counter (tcnt) SHALL count oversample ticks within a bit; a 3-bit bit index (bidx) SHALL select the data bit, LSB first.
REQ-016 IDLE -> START SHALL occur on a tick with RxD_sync=0, clearing tcnt.
REQ-017 In START, on the tick where tcnt reaches 7 (mid start bit): if RxD_sync=1, go to IDLE (glitch rejected, no output pulse); else go to DATA with tcnt=0 and bidx=0.
REQ-018 In DATA, each time tcnt wraps 15->0 (16 ticks), RxD_sync SHALL be shifted into the data shift register; after bidx=7 is sampled, go to STOP.
REQ-019 In STOP, after 16 ticks: if RxD_sync=1, load RxD_data from the shift register, pulse RxD_data_ready, and go to IDLE.
REQ-020 In STOP, after 16 ticks with RxD_sync=0: pulse RxD_frame_err, leave RxD_data unchanged, no ready pulse, and go to WAIT_HIGH.
REQ-021 WAIT_HIGH SHALL remain until a tick with RxD_sync=1, then go to IDLE (a break or stuck-low line produces exactly one frame_err).
REQ-022 A gap counter SHALL count ticks while in IDLE with RxD_sync=1, saturating at 160. It SHALL clear on any tick with RxD_sync=0 and whenever the state leaves IDLE.
REQ-023 RxD_idle SHALL equal (gap counter == 160); RxD_endofpacket SHALL pulse once on the 159->160 transition and SHALL NOT repeat while the line stays idle.
REQ-024 The ready pulse and RxD_data update SHALL occur on the same clk; the pulse SHALL be exactly one clk wide.
REQ-025 Back-to-back frames with one stop bit SHALL be received without loss (IDLE is entered before the next start edge's first tick).

Reset
REQ-026 On a reset clk edge: state=IDLE; tcnt, bidx, accumulator and shift register=0; synchronizer flops=1; RxD_data=8'h00; RxD_data_ready, RxD_frame_err, RxD_busy and RxD_endofpacket=0; gap counter=0, so RxD_idle=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no ready or frame_err pulse. After release, a line still low SHALL be treated as a new start bit only per REQ-016.

Verification
REQ-028 Bench SHALL drive frame 0xA5 (start, 8 bits LSB-first, stop) at 115200 baud -> RxD_data=0xA5 with a single one-clk RxD_data_ready, RxD_frame_err=0.
REQ-029 Bench SHALL drive a 3-oversample-tick low glitch -> no ready pulse, RxD_busy returns to 0, RxD_data unchanged.
REQ-030 Bench SHALL drive 0x3C with the stop bit low, then hold the line low for 2 bit times, then high -> exactly one RxD_frame_err pulse, RxD_data holds its previous value, and the next 0x55 frame is received correctly.
REQ-031 Bench SHALL drive back-to-back 0x00 then 0xFF with one stop bit -> two ready pulses carrying 0x00 then 0xFF.
REQ-032 Bench SHALL hold the line high after a frame for 160 ticks -> one RxD_endofpacket pulse and RxD_idle=1; on the next start bit, RxD_idle=0.
REQ-033 Bench SHALL assert reset during bit 4 of a frame, then deliver 0x81 -> no pulse from the aborted frame, and RxD_data=0x81 from the new frame.
